// File: rtl/duty_pkg.sv
// Shared defaults, the duty bus type and the slew FSM state encoding for the
// duty command controller.
package duty_pkg;

    localparam int unsigned REG_LEN  = 20;
    localparam int unsigned MAX_DUTY = 1000000;
    localparam int unsigned STEP     = 100000;

    typedef logic [REG_LEN:0] duty_t;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } slew_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Turns one raw asynchronous push-button into a single-cycle press pulse:
// two-flop synchronizer, stability counter, stable level and rising-edge detect.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stable_q;
    logic             stable_d;
    logic             stable_prev_q;
    logic             press_q;

    // Bring the raw button into the clock domain through two flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive disagreeing cycles; accept the new level once the count reaches the limit.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Debounce state plus a registered rising-edge pulse of the stable level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            press_q       <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            press_q       <= stable_q & ~stable_prev_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/duty_cmd_ctrl.sv
// Front-end for the PWM generator: debounced up/down buttons and a direct load
// set a clamped duty target, and a slew FSM walks duty_val toward it at a
// bounded rate, strobing val_en with every new value.
module duty_cmd_ctrl
    import duty_pkg::slew_state_t, duty_pkg::IDLE, duty_pkg::RAMP;
#(
    parameter int unsigned REG_LEN         = duty_pkg::REG_LEN,
    parameter int unsigned MAX_DUTY        = duty_pkg::MAX_DUTY,
    parameter int unsigned STEP            = duty_pkg::STEP,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned SLEW_DIV        = 100,
    parameter int unsigned SLEW_STEP       = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             load_en,
    input  logic [REG_LEN:0] load_val,
    output logic [REG_LEN:0] duty_val,
    output logic             val_en,
    output logic             busy
);

    localparam int unsigned DW = REG_LEN + 1;
    localparam int unsigned AW = REG_LEN + 2;
    localparam int unsigned PW = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;

    localparam logic [DW-1:0] MAX_D       = DW'(MAX_DUTY);
    localparam logic [AW-1:0] MAX_A       = AW'(MAX_DUTY);
    localparam logic [AW-1:0] STEP_A      = AW'(STEP);
    localparam logic [AW-1:0] SLEW_STEP_A = AW'(SLEW_STEP);
    localparam logic [PW-1:0] PRE_LAST    = PW'(SLEW_DIV - 1);

    logic          up_press;
    logic          down_press;

    logic [DW-1:0] target_q;
    logic [DW-1:0] target_d;
    logic [AW-1:0] load_a;
    logic [AW-1:0] sum_a;
    logic [AW-1:0] diff_a;

    slew_state_t   state_q;
    slew_state_t   state_d;
    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic [DW-1:0] duty_q;
    logic [DW-1:0] duty_d;
    logic          val_en_q;
    logic          val_en_d;
    logic [AW-1:0] tgt_a;
    logic [AW-1:0] duty_a;
    logic [AW-1:0] gap_a;
    logic [AW-1:0] move_a;
    logic [AW-1:0] next_a;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_up (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btn_up),
        .press_o(up_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_down (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btn_down),
        .press_o(down_press)
    );

    // Next target: load beats buttons, opposing presses cancel, results saturate at 0 and MAX_DUTY.
    always_comb begin
        target_d = target_q;
        load_a   = {1'b0, load_val};
        sum_a    = {1'b0, target_q} + STEP_A;
        diff_a   = {1'b0, target_q} - STEP_A;
        if (load_en) begin
            target_d = (load_a > MAX_A) ? MAX_D : load_val;
        end else if (up_press && !down_press) begin
            target_d = (sum_a > MAX_A) ? MAX_D : sum_a[DW-1:0];
        end else if (down_press && !up_press) begin
            target_d = ({1'b0, target_q} >= STEP_A) ? diff_a[DW-1:0] : '0;
        end
    end

    // Hold the clamped target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q <= '0;
        end else begin
            target_q <= target_d;
        end
    end

    // Slew FSM: every SLEW_DIV cycles in RAMP step toward the current target by at most SLEW_STEP.
    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        duty_d   = duty_q;
        val_en_d = 1'b0;
        tgt_a    = {1'b0, target_q};
        duty_a   = {1'b0, duty_q};
        gap_a    = (tgt_a >= duty_a) ? (tgt_a - duty_a) : (duty_a - tgt_a);
        move_a   = (gap_a > SLEW_STEP_A) ? SLEW_STEP_A : gap_a;
        next_a   = (tgt_a >= duty_a) ? (duty_a + move_a) : (duty_a - move_a);
        case (state_q)
            IDLE: begin
                if (duty_q != target_q) begin
                    state_d = RAMP;
                    pre_d   = '0;
                end
            end
            RAMP: begin
                if (pre_q == PRE_LAST) begin
                    pre_d = '0;
                    if (duty_q == target_q) begin
                        state_d = IDLE;
                    end else begin
                        duty_d   = next_a[DW-1:0];
                        val_en_d = 1'b1;
                        if (next_a == tgt_a) begin
                            state_d = IDLE;
                        end
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Slew state, prescaler and the registered command outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pre_q    <= '0;
            duty_q   <= '0;
            val_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            duty_q   <= duty_d;
            val_en_q <= val_en_d;
        end
    end

    assign duty_val = duty_q;
    assign val_en   = val_en_q;
    assign busy     = (state_q == RAMP);

endmodule

// File: doc/duty_cmd_ctrl.md
# duty_cmd_ctrl

Front-end controller that produces the `duty_val` / `val_en` command pair consumed by `PWM_Generator_Verilog`. It debounces two raw push-buttons into single step requests and accepts a direct load value. It keeps a clamped duty target and slews the output duty toward that target at a bounded rate. Sits directly upstream of the PWM generator in the 100 MHz clock domain.

## Interface
Parameters:
- `REG_LEN`, 20: duty MSB index; all duty buses are `REG_LEN+1` bits wide.
- `MAX_DUTY`, 1000000: full-scale duty, in PWM counts.
- `STEP`, 100000: target change per button press (10 %).
- `DEBOUNCE_CYCLES`, 1000000: stable cycles required before a button change is accepted (10 ms).
- `SLEW_DIV`, 100: clock cycles between slew updates.
- `SLEW_STEP`, 1000: maximum `duty_val` change per slew update.

Ports:
- `clk`  in  1: system clock, 100 MHz.
- `rst_n`  in  1: reset. **One clock; reset is asynchronous and active-low.**
- `btn_up`  in  1: raw asynchronous increase button, active-high.
- `btn_down`  in  1: raw asynchronous decrease button, active-high.
- `load_en`  in  1: synchronous one-cycle strobe that loads `load_val` into the target.
- `load_val`  in  REG_LEN+1: direct target value.
- `duty_val`  out  REG_LEN+1: current commanded duty; reset value 0.
- `val_en`  out  1: one-cycle strobe, coincident with each new `duty_val`; reset value 0.
- `busy`  out  1: high while the slew FSM is in RAMP; reset value 0.

## Operation
- Each button passes through a 2-flop synchronizer, then a debouncer, then rising-edge detection.
- Debouncer:
  - A counter increments while the synchronized input differs from the `stable` state.
  - The counter clears whenever the two agree.
  - When the count reaches `DEBOUNCE_CYCLES`, `stable` takes the input value and the counter clears.
- A rising edge of `stable` produces a one-cycle registered `press` pulse. Release produces no pulse.
- Target register (reset 0), with this priority:
  - `load_en`: target = min(`load_val`, `MAX_DUTY`).
  - Else up pulse only: target = min(target + `STEP`, `MAX_DUTY`).
  - Else down pulse only: target = (target ≥ `STEP`) ? target − `STEP` : 0.
  - Up and down pulses in the same cycle: target unchanged.
- Arithmetic width: sums and differences are computed at `REG_LEN+2` bits before clamping. There is no wrap-around at either end.
- Slew FSM states:
  - IDLE: if `duty_val` ≠ target, go to RAMP and clear the prescaler.
  - RAMP: the prescaler counts from 0 to `SLEW_DIV`−1. At terminal count:
    - `duty_val` moves toward the target by min(`SLEW_STEP`, |target − `duty_val`|).
    - `val_en` pulses.
    - If the new `duty_val` equals the target, go to IDLE.
- Target change during RAMP:
  - Direction is re-evaluated at every update. The prescaler is not restarted.
  - If the target becomes equal to `duty_val`, go to IDLE at the next terminal count, with no `val_en` pulse.
- `rst_n` low at any time:
  - All registers clear immediately: synchronizers, debounce counters, target, `duty_val`, prescaler, FSM = IDLE.
  - `val_en` and `busy` drop without waiting for a clock.

## Timing
- Synchronizer latency: 2 cycles.
- Debounce latency: `DEBOUNCE_CYCLES` cycles after the synchronized input settles.
- `press` is asserted the cycle after `stable` rises. The target updates at the edge that ends the `press` cycle.
- `load_en` sampled at edge N: target is valid after edge N.
- IDLE → RAMP: the cycle after the mismatch is first seen.
- The first `duty_val` update comes `SLEW_DIV` cycles after entering RAMP, then every `SLEW_DIV` cycles.
- `val_en` is high for exactly the one cycle in which the new `duty_val` first appears.
- A full 0 → `MAX_DUTY` ramp takes ceil(`MAX_DUTY` / `SLEW_STEP`) × `SLEW_DIV` cycles (1 ms at defaults).
- `busy` falls in the same cycle as the final `val_en`.

## Structure
- Package `duty_pkg` holds: `REG_LEN`, `MAX_DUTY`, `STEP` defaults, the duty bus typedef, and the slew FSM state enum (IDLE, RAMP).
- Sub-module `btn_debounce`: synchronizer, debounce counter, `stable` register and edge detect. Parameter: `DEBOUNCE_CYCLES`. Output: `press`. Instantiated twice.
- Top level holds the target register, slew FSM, prescaler and output registers.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=16, `SLEW_DIV`=4, `SLEW_STEP`=1000, `STEP`=100000, `MAX_DUTY`=1000000.
- Reset: hold `rst_n` low 5 cycles, then release → `duty_val`=0, `val_en`=0 and `busy`=0 before and after release.
- Clean press: `btn_up` high for 30 cycles → target becomes 100000; `duty_val` rises in 100 steps of 1000; 100 `val_en` pulses, 4 cycles apart; `busy` falls with the final pulse.
- Bounce: toggle `btn_up` every 5 cycles for 80 cycles, then hold low → target stays 0 and no `val_en` occurs.
- Clamp: `load_val`=1500000 → target 1000000. Then an up press → target stays 1000000. Then `load_val`=50000 followed by a down press → target 0.
- Simultaneous and priority:
  - Up and down presses debounced to the same cycle → target unchanged.
  - `load_en` in the same cycle as an up pulse → load wins.
- Mid-ramp:
  - During a ramp to 750000, load 150000 when `duty_val`=200000 → the next update gives `duty_val`=199000 and the ramp ends at 150000.
  - Assert `rst_n` mid-ramp → `duty_val`=0 and `busy`=0 immediately.
